// File: rtl/cfu_mac_pkg.sv
// Shared constants for the CFU MAC pipeline: opcodes, FSM states, lane widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cfu_mac_pkg;

  // Opcodes carried in function_id[9:3]
  localparam logic [6:0] OP_MAC        = 7'd0;
  localparam logic [6:0] OP_SET_OFFSET = 7'd1;
  localparam logic [6:0] OP_READ_ACC   = 7'd2;
  localparam logic [6:0] OP_SET_CLAMP  = 7'd6;
  localparam logic [6:0] OP_CLAMP      = 7'd7;
  localparam logic [6:0] OP_DRAIN      = 7'd8;

  // One lane product (a_i + offset) * b_i is kept at 17 bits signed
  localparam int LANE_W    = 17;
  localparam int NUM_LANES = 4;
  // Sum of four lane products needs two extra bits of headroom
  localparam int SUM_W     = LANE_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cfu_mac_lanes.sv
// Four signed int8 lanes: (a_i + offset) * b_i registered, then summed.
// Latency: products registered on the load edge; sum is valid the cycle after.
// Backpressure: none; the parent loads only when it accepts a command.
module cfu_mac_lanes
  import cfu_mac_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  input  logic signed [15:0]      offset,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [LANE_W-1:0] a_off  [NUM_LANES];
  logic signed [LANE_W-1:0] b_ext  [NUM_LANES];
  logic signed [LANE_W-1:0] prod_d [NUM_LANES];
  logic signed [LANE_W-1:0] prod_q [NUM_LANES];

  // Offset-adjust each A lane and multiply by the sign-extended B lane
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      a_off[i]  = LANE_W'($signed(a[8*i +: 8])) + LANE_W'(offset);
      b_ext[i]  = LANE_W'($signed(b[8*i +: 8]));
      prod_d[i] = a_off[i] * b_ext[i];
    end
  end

  // Capture the lane products when a command is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Sign-extended sum of the registered products
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++) sum = sum + SUM_W'(prod_q[i]);
  end

endmodule

// File: rtl/cfu_mac_pipe.sv
// CFU MAC unit: int8x4 dot-product accumulate bank with offset, clamp and drain.
// Latency: rsp_valid rises 2 cycles after command acceptance; one command in flight.
// Backpressure: response held stable until rsp_ready; cmd_ready only in IDLE.
// Optional: define CFU_MAC_SATURATE_EN to saturate MAC results instead of wrapping.
module cfu_mac_pipe
  import cfu_mac_pkg::*;
#(
  parameter int NUM_ACC = 4,
  parameter int ACC_W   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  state_e                    state;
  logic [6:0]                op_q;
  logic [2:0]                sel_q;
  logic [31:0]               in0_q;
  logic [31:0]               in1_q;
  logic signed [15:0]        offset_q;
  logic signed [ACC_W-1:0]   acc_q [NUM_ACC];
  logic signed [ACC_W-1:0]   min_q;
  logic signed [ACC_W-1:0]   max_q;

  logic                      accept;
  logic                      sel_ok;
  logic signed [SUM_W-1:0]   lane_sum;
  logic signed [ACC_W-1:0]   acc_sel;
  logic signed [ACC_W-1:0]   mac_res;
  logic signed [ACC_W:0]     clamp_in;
  logic signed [ACC_W:0]     drain_in;
  logic signed [ACC_W-1:0]   rsp_d;
  logic signed [ACC_W-1:0]   acc_wdat;
  logic                      acc_wr;
  logic                      off_wr;
  logic                      clamp_wr;

  assign accept = cmd_valid && cmd_ready;
  assign sel_ok = (int'(sel_q) < NUM_ACC);

  cfu_mac_lanes u_lanes (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .a       (cmd_payload_inputs_0),
    .b       (cmd_payload_inputs_1),
    .offset  (offset_q),
    .sum     (lane_sum)
  );

  // Min wins whenever the configured range is inverted
  function automatic logic signed [ACC_W-1:0] clamp_f(
    input logic signed [ACC_W:0]   v,
    input logic signed [ACC_W-1:0] lo,
    input logic signed [ACC_W-1:0] hi
  );
    logic signed [ACC_W:0] lo_w;
    logic signed [ACC_W:0] hi_w;
    lo_w = (ACC_W+1)'(lo);
    hi_w = (ACC_W+1)'(hi);
    if (lo_w > hi_w)       clamp_f = lo;
    else if (v <= lo_w)    clamp_f = lo;
    else if (v >= hi_w)    clamp_f = hi;
    else                   clamp_f = v[ACC_W-1:0];
  endfunction

  // Read mux for the selected accumulator
  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (sel_q == 3'(i)) acc_sel = acc_q[i];
    end
  end

`ifdef CFU_MAC_SATURATE_EN
  localparam int WIDE_W = 34;
  localparam logic signed [WIDE_W-1:0] ACC_MAX = $signed((34'd1 << (ACC_W-1)) - 34'd1);
  localparam logic signed [WIDE_W-1:0] ACC_MIN = $signed(-(34'd1 << (ACC_W-1)));
  logic signed [WIDE_W-1:0] mac_wide;

  // MAC at full width, then pinned to the signed accumulator range
  always_comb begin
    mac_wide = WIDE_W'(acc_sel) + WIDE_W'(lane_sum);
    if (mac_wide > ACC_MAX)      mac_res = ACC_MAX[ACC_W-1:0];
    else if (mac_wide < ACC_MIN) mac_res = ACC_MIN[ACC_W-1:0];
    else                         mac_res = mac_wide[ACC_W-1:0];
  end
`else
  // MAC wraps modulo 2^ACC_W
  always_comb begin
    mac_res = acc_sel + ACC_W'(lane_sum);
  end
`endif

  // Clamp operands: one bit wider than the accumulator so DRAIN never wraps
  always_comb begin
    clamp_in = (ACC_W+1)'($signed(in0_q[ACC_W-1:0]));
    drain_in = (ACC_W+1)'(acc_sel) + (ACC_W+1)'($signed(in0_q[ACC_W-1:0]));
  end

  // Opcode decode for the EXEC cycle: response value and bank/config writes
  always_comb begin
    rsp_d    = '0;
    acc_wdat = '0;
    acc_wr   = 1'b0;
    off_wr   = 1'b0;
    clamp_wr = 1'b0;
    if (sel_ok) begin
      case (op_q)
        OP_MAC: begin
          acc_wr   = 1'b1;
          acc_wdat = mac_res;
          rsp_d    = mac_res;
        end
        OP_SET_OFFSET: begin
          off_wr = 1'b1;
          acc_wr = 1'b1;
        end
        OP_READ_ACC:  rsp_d = acc_sel;
        OP_SET_CLAMP: clamp_wr = 1'b1;
        OP_CLAMP:     rsp_d = clamp_f(clamp_in, min_q, max_q);
        OP_DRAIN: begin
          rsp_d  = clamp_f(drain_in, min_q, max_q);
          acc_wr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered handshake outputs and response payload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= ST_IDLE;
      cmd_ready             <= 1'b1;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      op_q                  <= '0;
      sel_q                 <= '0;
      in0_q                 <= '0;
      in1_q                 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_EXEC;
            cmd_ready <= 1'b0;
            op_q      <= cmd_payload_function_id[9:3];
            sel_q     <= cmd_payload_function_id[2:0];
            in0_q     <= cmd_payload_inputs_0;
            in1_q     <= cmd_payload_inputs_1;
          end
        end
        ST_EXEC: begin
          state                 <= ST_RESP;
          rsp_valid             <= 1'b1;
          rsp_payload_outputs_0 <= 32'(rsp_d);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Accumulator bank and configuration registers, written on the EXEC->RESP edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      offset_q <= '0;
      min_q    <= '0;
      max_q    <= '0;
    end else if (state == ST_EXEC) begin
      if (acc_wr) begin
        for (int i = 0; i < NUM_ACC; i++) begin
          if (sel_q == 3'(i)) acc_q[i] <= acc_wdat;
        end
      end
      if (off_wr) offset_q <= in0_q[15:0];
      if (clamp_wr) begin
        min_q <= in0_q[ACC_W-1:0];
        max_q <= in1_q[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cfu_mac_pipe.sv
// Self-checking bench for cfu_mac_pipe (ACC_W=16, NUM_ACC=4): directed cases plus
// randomized commands against an arithmetic reference model.
// Expected overflow behaviour follows CFU_MAC_SATURATE_EN when defined.
module tb_cfu_mac_pipe;

  localparam int NACC = 4;
  localparam int AW   = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;

  int n_chk = 0;
  int n_bad = 0;

  longint m_acc [NACC];
  longint m_off;
  longint m_min;
  longint m_max;

  always #5 clk = ~clk;

  cfu_mac_pipe #(.NUM_ACC(NACC), .ACC_W(AW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_dat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint wrapw(input longint v);
    longint m;
    m = v & ((longint'(1) << AW) - 1);
    if (m >= (longint'(1) << (AW - 1))) m = m - (longint'(1) << AW);
    return m;
  endfunction

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    if (lo > hi) return lo;
    if (v <= lo) return lo;
    if (v >= hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NACC; i++) m_acc[i] = 0;
    m_off = 0;
    m_min = 0;
    m_max = 0;
  endtask

  function automatic logic [31:0] model(input int op, input int sel,
                                        input logic [31:0] a, input logic [31:0] b);
    longint  res;
    longint  s;
    longint  p;
    byte     ba;
    byte     bb;
    shortint so;
    res = 0;
    if (sel >= NACC) return 32'd0;
    case (op)
      0: begin
        s = m_acc[sel];
        for (int i = 0; i < 4; i++) begin
          ba = a[8*i +: 8];
          bb = b[8*i +: 8];
          p  = (longint'(ba) + m_off) * longint'(bb);
          p  = p & 64'h1FFFF;
          if (p > 64'sd65535) p = p - 64'sd131072;
          s  = s + p;
        end
`ifdef CFU_MAC_SATURATE_EN
        s = clampv(s, -(longint'(1) << (AW - 1)), (longint'(1) << (AW - 1)) - 1);
`else
        s = wrapw(s);
`endif
        m_acc[sel] = s;
        res = s;
      end
      1: begin
        so = a[15:0];
        m_off = so;
        m_acc[sel] = 0;
      end
      2: res = m_acc[sel];
      6: begin
        m_min = wrapw(longint'(a));
        m_max = wrapw(longint'(b));
      end
      7: res = clampv(wrapw(longint'(a)), m_min, m_max);
      8: begin
        res = clampv(m_acc[sel] + wrapw(longint'(a)), m_min, m_max);
        m_acc[sel] = 0;
      end
      default: res = 0;
    endcase
    return 32'(res);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic issue(input string tag, input int op, input int sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] got);
    logic [31:0] exp;
    int n;
    exp = model(op, sel, a, b);
    cmd_valid = 1'b1;
    fid = {7'(op), 3'(sel)};
    in0 = a;
    in1 = b;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_rdy", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = (hold == 0);
    chk("exec_vld", 32'(rsp_valid), 32'd0);
    chk("exec_rdy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("lat_vld", 32'(rsp_valid), 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    got = rsp_dat;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_vld", 32'(rsp_valid), 32'd1);
      chk("hold_dat", rsp_dat, got);
      chk("hold_rdy", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_vld", 32'(rsp_valid), 32'd0);
    chk("done_rdy", 32'(cmd_ready), 32'd1);
    chk(tag, got, exp);
  endtask

  // Accept a MAC then assert reset in EXEC (stage 1) or RESP (stage 2)
  task automatic reset_mid(input int stage);
    int n;
    cmd_valid = 1'b1;
    fid = {7'd0, 3'd0};
    in0 = 32'h05050505;
    in1 = 32'h03030303;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("rm_cmd_rdy", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    if (stage == 2) begin
      @(negedge clk);
      chk("rm_resp_vld", 32'(rsp_valid), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("rm_vld", 32'(rsp_valid), 32'd0);
    chk("rm_dat", rsp_dat, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rm_post_rdy", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rm_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    int op;
    int sel;
    int pick;

    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_dat", rsp_dat, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 32'(cmd_ready), 32'd1);

    // Offset case
    issue("setoff", 1, 0, 32'd128, 32'd0, 0, r);
    chk("setoff_lit", r, 32'd0);
    issue("mac_off", 0, 0, 32'h01010101, 32'h02020202, 0, r);
    chk("mac_off_lit", r, 32'h00000408);

    // Zero cancel: a + offset == 0 in every lane
    issue("zero_cancel", 0, 0, 32'h80808080, 32'h7F7F7F7F, 0, r);
    chk("zero_cancel_lit", r, 32'h00000408);

    // Clamp
    issue("setclamp", 6, 0, 32'hFFFFFF80, 32'd127, 0, r);
    issue("clamp_hi", 7, 0, 32'd300, 32'd0, 0, r);
    chk("clamp_hi_lit", r, 32'd127);
    issue("clamp_lo", 7, 0, 32'hFFFFFED4, 32'd0, 0, r);
    chk("clamp_lo_lit", r, 32'hFFFFFF80);
    issue("clamp_mid", 7, 0, 32'd42, 32'd0, 1, r);
    chk("clamp_mid_lit", r, 32'd42);
    issue("setclamp_inv", 6, 0, 32'd10, 32'd5, 0, r);
    issue("clamp_inv", 7, 0, 32'd7, 32'd0, 0, r);
    chk("clamp_inv_lit", r, 32'd10);

    // Backpressure and bank isolation
    issue("mac_sel1_hold", 0, 1, 32'h01010101, 32'h02020202, 5, r);
    issue("read_sel0", 2, 0, 32'd0, 32'd0, 0, r);
    chk("read_sel0_lit", r, 32'h00000408);
    issue("mac_sel5", 0, 5, 32'h01010101, 32'h02020202, 0, r);
    chk("mac_sel5_lit", r, 32'd0);
    issue("unknown_op", 3, 0, 32'h12345678, 32'h9ABCDEF0, 0, r);
    chk("unknown_op_lit", r, 32'd0);

    // Drain with a wide range
    issue("setclamp_wide", 6, 0, 32'hFFFF8000, 32'h00007FFF, 0, r);
    issue("drain0", 8, 0, 32'h00000010, 32'd0, 0, r);
    chk("drain0_lit", r, 32'h00000418);
    issue("read_drained", 2, 0, 32'd0, 32'd0, 0, r);
    chk("read_drained_lit", r, 32'd0);

    // Overflow: 32 MACs of 0x408 on a 16-bit accumulator
    issue("ovf_setoff", 1, 2, 32'd128, 32'd0, 0, r);
    for (int i = 0; i < 32; i++) begin
      issue("ovf_mac", 0, 2, 32'h01010101, 32'h02020202, 0, r);
    end
`ifdef CFU_MAC_SATURATE_EN
    chk("ovf_final", r, 32'h00007FFF);
`else
    chk("ovf_final", r, 32'hFFFF8100);
`endif

    // Randomized commands
    for (int i = 0; i < 250; i++) begin
      pick = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 5);
      case (pick)
        0, 1, 2, 3: op = 0;
        4: op = 1;
        5: op = 2;
        6: begin
          op = 6;
          if ($urandom_range(0, 1) == 1) begin
            a = -$urandom_range(0, 5000);
            b = $urandom_range(0, 5000);
          end
        end
        7: op = 7;
        8: op = 8;
        default: op = ($urandom_range(0, 1) == 1) ? 3 : 100;
      endcase
      if (op == 1) a = $urandom_range(0, 400) - 200;
      issue("rand_rsp", op, sel, a, b, $urandom_range(0, 2), r);
    end

    // Reset while a command is in flight
    issue("pre_rst_mac", 0, 1, 32'h01020304, 32'h05060708, 0, r);
    reset_mid(1);
    for (int s = 0; s < NACC; s++) begin
      issue("post_rst_read", 2, s, 32'd0, 32'd0, 0, r);
      chk("post_rst_read_lit", r, 32'd0);
    end
    issue("post_rst_mac", 0, 0, 32'h01010101, 32'h02020202, 0, r);
    chk("post_rst_mac_lit", r, 32'd8);
    reset_mid(2);
    issue("post_rst2_read", 2, 0, 32'd0, 32'd0, 0, r);
    chk("post_rst2_read_lit", r, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/cfu_mac_pipe.md
CFU_MAC_PIPE -- requirements
Module: cfu_mac_pipe

Interface
REQ-001 SHALL have parameter NUM_ACC, default 4, meaning the number of independent accumulators (1..8).
REQ-002 SHALL have parameter ACC_W, default 32, meaning the accumulator and result width in bits (16..32).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock; one clock, all state on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_payload_function_id  in  10  [9:3] opcode, [2:0] accumulator select.
- cmd_payload_inputs_0  in  32  operand A: four signed int8 lanes, or a scalar.
- cmd_payload_inputs_1  in  32  operand B: four signed int8 lanes, or a scalar.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response taken.
- rsp_payload_outputs_0  out  32  result, sign-extended from ACC_W.

Function
REQ-004 SHALL use FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE->EXEC on cmd_valid&&cmd_ready.
- EXEC->RESP unconditionally.
- RESP->IDLE on rsp_ready.
REQ-005 SHALL drive cmd_ready high only in IDLE, so exactly one command is in flight.
REQ-006 SHALL raise rsp_valid exactly 2 cycles after acceptance, and hold it and the payload stable until rsp_ready; rsp_ready in the same cycle rsp_valid rises completes the transfer.
REQ-007 SHALL register lane products ((a_i + offset) * b_i, 17-bit signed, i=0..3) in EXEC; the accumulator updates on the EXEC->RESP edge.
REQ-008 SHALL implement these opcodes:
- 0 MAC: acc[sel] += sum of the four lane products; rsp = new acc[sel].
- 1 SET_OFFSET: offset <= inputs_0[15:0] signed; acc[sel] <= 0; rsp = 0.
- 2 READ_ACC: rsp = acc[sel].
- 6 SET_CLAMP: min <= inputs_0, max <= inputs_1; rsp = 0.
- 7 CLAMP: rsp = clamp(inputs_0).
- 8 DRAIN: rsp = clamp(acc[sel] + inputs_0); acc[sel] <= 0.
REQ-009 SHALL define clamp(v) as: min if v <= min, else max if v >= max, else v; when min > max, the result is min.
REQ-010 SHALL treat an unknown opcode or sel >= NUM_ACC as a no-op with rsp = 0, still following the REQ-006 timing.
REQ-011 SHALL wrap the accumulator modulo 2^ACC_W when CFU_MAC_SATURATE_EN is undefined.
REQ-012 SHALL compute DRAIN's addition at ACC_W+1 bits before clamping, so the addition never wraps.

Reset
REQ-013 SHALL, on reset_n low and regardless of state:
- go to IDLE;
- set rsp_valid=0 and rsp_payload_outputs_0=0;
- set every accumulator, offset, min and max to 0.
REQ-014 SHALL have cmd_ready=1 in the first cycle after reset_n deasserts; an in-flight command is discarded with no response.

Configuration
REQ-015 SHALL, with macro CFU_MAC_SATURATE_EN defined, saturate MAC results to signed ACC_W limits [-2^(ACC_W-1), 2^(ACC_W-1)-1]; without it, wrap per REQ-011.

Structure
REQ-016 SHALL place the opcode constants, the FSM state typedef and the lane-product width constant in package cfu_mac_pkg.
REQ-017 SHALL implement the four-lane offset-multiply and registered sum in sub-module cfu_mac_lanes; the FSM, accumulator bank and clamp stay in cfu_mac_pipe.

Verification
REQ-018 Offset: SET_OFFSET 128, then MAC A=0x01010101, B=0x02020202, sel 0 -> rsp 0x00000408 at acceptance+2.
REQ-019 Zero cancel: offset 128, MAC A=0x80808080, B=0x7F7F7F7F -> rsp = previous acc unchanged.
REQ-020 Clamp: SET_CLAMP -128/127; CLAMP 300 -> 127; CLAMP -300 -> 0xFFFFFF80; SET_CLAMP 10/5, CLAMP 7 -> 10.
REQ-021 Overflow: ACC_W=16, offset 128, 32x MAC of REQ-018 operands -> final rsp 0xFFFF8100 without macro, 0x00007FFF with CFU_MAC_SATURATE_EN.
REQ-022 Backpressure/bank: hold rsp_ready=0 for 5 cycles -> rsp_valid and payload stable, cmd_ready=0; MAC on sel 1 leaves sel 0 intact; sel 5 with NUM_ACC=4 -> rsp 0.
REQ-023 Reset mid-op: pulse reset_n low during EXEC -> rsp_valid=0 immediately, READ_ACC afterwards -> 0.
